// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the BNN frame loader.
//   IMG_BITS/BYTE_W/NUM_BYTES : frame geometry (900 image bits + 4 pad bits)
//   RESULT_W, DIGIT_TIMEOUT   : digit width and the code reported on watchdog expiry
//   TIMEOUT_CYCLES            : inference watchdog limit (only used with BNN_TIMEOUT_EN)
package bnn_pkg;

  localparam int unsigned IMG_BITS       = 904;
  localparam int unsigned IMG_SIDE       = 30;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned NUM_BYTES      = IMG_BITS / BYTE_W;
  localparam int unsigned RESULT_W       = 4;
  localparam logic [RESULT_W-1:0] DIGIT_TIMEOUT = 4'hF;
  localparam int unsigned TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    INFER  = 2'd1,
    CLEAR  = 2'd2,
    REPORT = 2'd3
  } loader_state_t;

endpackage

// File: rtl/bnn_frame_loader.sv
// Host-side BNN driver: packs a 113-byte stream into the 904-bit frame, runs the
// enable/result/clear handshake with the BNN interface and reports the digit.
// Optional inference watchdog: define BNN_TIMEOUT_EN.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   rx_data/rx_valid/rx_ready        byte stream in
//   img_out, img_buffer_full         packed frame and frame-complete flag
//   bnn_enable, bnn_clear            BNN start/hold and result release
//   result_in/result_ready           BNN digit and its valid
//   digit_out/digit_valid/digit_ack  digit to downstream
//   frame_abort                      discard partial frame / pending digit
//   busy, timeout_err                activity and sticky watchdog flags
module bnn_frame_loader
  import bnn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_buffer_full,
  output logic                bnn_enable,
  output logic                bnn_clear,
  input  logic [RESULT_W-1:0] result_in,
  input  logic                result_ready,
  output logic [RESULT_W-1:0] digit_out,
  output logic                digit_valid,
  input  logic                digit_ack,
  input  logic                frame_abort,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned CNT_W    = $clog2(NUM_BYTES);
  localparam int unsigned LAST_IDX = NUM_BYTES - 1;

  loader_state_t       state, state_next;
  logic [CNT_W-1:0]    count, count_next;
  logic                shift_en;
  logic                digit_load;
  logic [RESULT_W-1:0] digit_next;
  logic                wd_hit;

`ifdef BNN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] wd_cnt;

  // Watchdog: counts cycles spent in INFER, restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != INFER) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + TO_W'(1);
    end
  end

  assign wd_hit = (state == INFER) && (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !result_ready;

  // Sticky error; a set in the same cycle as an abort wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (wd_hit) begin
      timeout_err <= 1'b1;
    end else if (frame_abort) begin
      timeout_err <= 1'b0;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state, byte counter and datapath load enables.
  always_comb begin
    state_next = state;
    count_next = count;
    shift_en   = 1'b0;
    digit_load = 1'b0;
    digit_next = result_in;
    case (state)
      LOAD: begin
        // An abort wins over a byte accepted in the same cycle.
        if (frame_abort) begin
          count_next = '0;
        end else if (rx_valid && rx_ready) begin
          shift_en = 1'b1;
          if (count == CNT_W'(LAST_IDX)) begin
            count_next = '0;
            state_next = INFER;
          end else begin
            count_next = count + CNT_W'(1);
          end
        end
      end
      INFER: begin
        if (result_ready) begin
          digit_load = 1'b1;
          state_next = CLEAR;
        end else if (wd_hit) begin
          digit_load = 1'b1;
          digit_next = DIGIT_TIMEOUT;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (!result_ready) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        if (digit_ack || frame_abort) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Registered outputs, decoded from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_out         <= '0;
      digit_out       <= '0;
      rx_ready        <= 1'b1;
      img_buffer_full <= 1'b0;
      bnn_enable      <= 1'b0;
      bnn_clear       <= 1'b0;
      digit_valid     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      if (shift_en) begin
        img_out <= {img_out[IMG_BITS-BYTE_W-1:0], rx_data};
      end
      if (digit_load) begin
        digit_out <= digit_next;
      end
      rx_ready        <= (state_next == LOAD);
      img_buffer_full <= (state_next == INFER);
      bnn_enable      <= (state_next == INFER);
      bnn_clear       <= (state_next == CLEAR);
      digit_valid     <= (state_next == REPORT);
      busy            <= (state_next != LOAD) || (count_next != '0);
    end
  end

endmodule

// File: tb/tb_bnn_frame_loader.sv
// Directed self-checking bench for bnn_frame_loader with a frame/digit scoreboard.
module tb_bnn_frame_loader;

  logic         clk;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [903:0] img_out;
  logic         img_buffer_full;
  logic         bnn_enable;
  logic         bnn_clear;
  logic [3:0]   result_in;
  logic         result_ready;
  logic [3:0]   digit_out;
  logic         digit_valid;
  logic         digit_ack;
  logic         frame_abort;
  logic         busy;
  logic         timeout_err;

  bnn_frame_loader dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .img_out(img_out), .img_buffer_full(img_buffer_full),
    .bnn_enable(bnn_enable), .bnn_clear(bnn_clear),
    .result_in(result_in), .result_ready(result_ready),
    .digit_out(digit_out), .digit_valid(digit_valid), .digit_ack(digit_ack),
    .frame_abort(frame_abort), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [903:0] exp_img = '0;
  logic [903:0] frame_q[$];
  logic [3:0]   digit_q[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  task automatic check_img(input string name, input logic [903:0] exp);
    int idx;
    n_total++;
    idx = -1;
    for (int i = 0; i < 113; i++) begin
      if (idx < 0 && img_out[i*8 +: 8] !== exp[i*8 +: 8]) idx = i;
    end
    assert (img_out === exp) n_pass++;
    else $error("FAIL %s: byte slot %0d got %0h expected %0h", name, idx,
                (idx >= 0) ? img_out[idx*8 +: 8] : 8'h0, (idx >= 0) ? exp[idx*8 +: 8] : 8'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    check("rx_ready_load", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    exp_img  = {exp_img[895:0], b};
  endtask

  // kind 0: base+i ramp, 1: constant base, 2: random bytes
  task automatic send_frame(input int kind, input logic [7:0] base, input bit gaps);
    logic [7:0] b;
    for (int i = 0; i < 113; i++) begin
      case (kind)
        0:       b = 8'(base + 8'(i));
        1:       b = base;
        default: b = 8'($urandom);
      endcase
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) tick();
      end
      send_byte(b);
      if (i == 111) check("no_infer_before_last", bnn_enable, 0);
    end
    frame_q.push_back(exp_img);
    check("bnn_enable_rise", bnn_enable, 1);
    check("img_full_rise", img_buffer_full, 1);
    check("rx_ready_infer", rx_ready, 0);
    check("busy_infer", busy, 1);
    check_img("frame", frame_q.pop_front());
  endtask

  task automatic do_result(input int delay, input int hold, input logic [3:0] d);
    for (int k = 0; k < delay; k++) begin
      check("enable_hold", bnn_enable, 1);
      check("rx_ready_held_off", rx_ready, 0);
      tick();
    end
    result_in    = d;
    result_ready = 1'b1;
    frame_abort  = 1'b0;
    digit_ack    = 1'b0;
    digit_q.push_back(d);
    tick();
    check("clear_entry", bnn_clear, 1);
    check("enable_drop", bnn_enable, 0);
    check("img_full_drop", img_buffer_full, 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("clear_held", bnn_clear, 1);
      check("no_report_yet", digit_valid, 0);
    end
    result_ready = 1'b0;
    tick();
    check("report_entry", digit_valid, 1);
    check("clear_release", bnn_clear, 0);
  endtask

  task automatic report_ack(input int hold);
    logic [3:0] d;
    d = digit_q.pop_front();
    check("digit_value", digit_out, 32'(d));
    for (int k = 0; k < hold; k++) begin
      tick();
      check("digit_valid_held", digit_valid, 1);
      check("digit_stable", digit_out, 32'(d));
    end
    digit_ack = 1'b1;
    tick();
    digit_ack = 1'b0;
    check("digit_valid_drop", digit_valid, 0);
    check("rx_ready_back", rx_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic [903:0] aa_frame;
    logic [903:0] saved;
    logic [3:0]   dropped;
    aa_frame     = {113{8'hAA}};
    rst_n        = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    result_in    = 4'h0;
    result_ready = 1'b0;
    digit_ack    = 1'b0;
    frame_abort  = 1'b0;

    #12;
    check("rst_rx_ready", rx_ready, 1);
    check_img("rst_img", '0);
    check("rst_digit", digit_out, 0);
    check("rst_digit_valid", digit_valid, 0);
    check("rst_enable", bnn_enable, 0);
    check("rst_full", img_buffer_full, 0);
    check("rst_clear", bnn_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    #1 rst_n = 1'b1;
    tick();

    // Ramp frame, result after 3 cycles, digit 7
    send_frame(0, 8'h00, 1'b0);
    check("t1_first_byte", 32'(img_out[903:896]), 32'h00);
    check("t1_last_byte", 32'(img_out[7:0]), 32'h70);
    do_result(3, 0, 4'd7);
    report_ack(3);

    // Gapped random stream, rx_valid held during inference, result held 5 cycles
    send_frame(2, 8'h00, 1'b1);
    saved    = exp_img;
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    do_result(2, 5, 4'd9);
    rx_valid = 1'b0;
    check_img("t2_frozen", saved);
    report_ack(1);

    // Abort after 50 bytes with a concurrent byte, then a fresh 0xAA frame
    for (int i = 0; i < 50; i++) send_byte(8'(i + 1));
    check("t4_busy_partial", busy, 1);
    rx_data     = 8'h55;
    rx_valid    = 1'b1;
    frame_abort = 1'b1;
    tick();
    rx_valid    = 1'b0;
    frame_abort = 1'b0;
    check("t4_busy_after_abort", busy, 0);
    check("t4_ready_after_abort", rx_ready, 1);
    send_frame(1, 8'hAA, 1'b0);
    check_img("t4_all_aa", aa_frame);
    do_result(2, 0, 4'd3);
    report_ack(0);

    // Abort and ack during INFER ignored; abort in REPORT drops the digit
    send_frame(0, 8'h10, 1'b0);
    frame_abort = 1'b1;
    digit_ack   = 1'b1;
    do_result(3, 1, 4'd4);
    report_ack(1);
    send_frame(0, 8'h20, 1'b0);
    do_result(1, 0, 4'd5);
    dropped     = digit_q.pop_front();
    check("t5_digit_before_drop", digit_out, 32'(dropped));
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    check("t5_drop_valid", digit_valid, 0);
    check("t5_drop_ready", rx_ready, 1);
    check("t5_drop_busy", busy, 0);

`ifdef BNN_TIMEOUT_EN
    // Watchdog expiry reports 4'hF; abort clears the sticky flag
    send_frame(2, 8'h00, 1'b0);
    repeat (1023) tick();
    check("to_still_infer", bnn_enable, 1);
    check("to_not_yet", timeout_err, 0);
    tick();
    check("to_flag", timeout_err, 1);
    check("to_digit", digit_out, 32'hF);
    check("to_clear", bnn_clear, 1);
    tick();
    check("to_report", digit_valid, 1);
    digit_q.push_back(4'hF);
    report_ack(0);
    check("to_sticky", timeout_err, 1);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    check("to_cleared", timeout_err, 0);
`endif

    // Async reset mid-load, then a clean frame
    for (int i = 0; i < 40; i++) send_byte(8'(i));
    #3 rst_n = 1'b0;
    #1;
    exp_img = '0;
    check("rst_mid_ready", rx_ready, 1);
    check("rst_mid_busy", busy, 0);
    check_img("rst_mid_img", '0);
    #2 rst_n = 1'b1;
    tick();
    send_frame(0, 8'h40, 1'b0);

    // Async reset during INFER
    #3 rst_n = 1'b0;
    #1;
    exp_img = '0;
    check("rst_inf_enable", bnn_enable, 0);
    check("rst_inf_full", img_buffer_full, 0);
    check("rst_inf_ready", rx_ready, 1);
    check_img("rst_inf_img", '0);
    #2 rst_n = 1'b1;
    tick();
    send_frame(0, 8'h80, 1'b0);
    do_result(0, 0, 4'd2);
    report_ack(0);

    check("sb_digits_empty", 32'(digit_q.size()), 0);
    check("sb_frames_empty", 32'(frame_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
